// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache.
// Read hits return same cycle; misses and all writes stall for memory.
module dcache_wt #(
   parameter int LINES      = 16,
   parameter int INDEX_BITS = 4,
   parameter int TAG_BITS   = 26
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_re,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      WRITE,
      RESP
   } state_t;

   state_t                state_q, state_d;
   logic [LINES-1:0]      valid_q, valid_d;
   logic [TAG_BITS-1:0]   tag_q  [LINES];
   logic [TAG_BITS-1:0]   tag_d  [LINES];
   logic [31:0]           data_q [LINES];
   logic [31:0]           data_d [LINES];
   logic                  rd_q, rd_d;
   logic [31:0]           hit_q, hit_d;
   logic [31:0]           miss_q, miss_d;

   logic [INDEX_BITS-1:0] idx;
   logic [TAG_BITS-1:0]   tag;
   logic                  hit;
   logic                  stall_c;
   logic [31:0]           rdata_c;
   logic                  unused_addr;

   assign idx         = cpu_addr[INDEX_BITS+1:2];
   assign tag         = cpu_addr[31:INDEX_BITS+2];
   assign hit         = valid_q[idx] && (tag_q[idx] == tag);
   assign unused_addr = ^cpu_addr[1:0];

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      rd_d    = rd_q;
      hit_d   = hit_q;
      miss_d  = miss_q;
      stall_c = 1'b0;
      rdata_c = 32'h0;
      unique case (state_q)
         IDLE: begin
            if (cpu_we) begin
               stall_c = 1'b1;
               rd_d    = 1'b0;
               state_d = WRITE;
            end else if (cpu_re) begin
               if (hit) begin
                  rdata_c = data_q[idx];
                  if (hit_q != 32'hFFFF_FFFF) hit_d = hit_q + 32'd1;
               end else begin
                  stall_c = 1'b1;
                  rd_d    = 1'b1;
                  state_d = FILL;
                  if (miss_q != 32'hFFFF_FFFF) miss_d = miss_q + 32'd1;
               end
            end
         end
         FILL: begin
            stall_c = 1'b1;
            if (mem_ready) begin
               valid_d[idx] = 1'b1;
               tag_d[idx]   = tag;
               data_d[idx]  = mem_rdata;
               state_d      = RESP;
            end
         end
         WRITE: begin
            stall_c = 1'b1;
            if (mem_ready) begin
               // No allocate: only a resident line is refreshed
               if (hit) data_d[idx] = cpu_wdata;
               state_d = RESP;
            end
         end
         RESP: begin
            if (rd_q) rdata_c = data_q[idx];
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         valid_q <= '0;
         rd_q    <= 1'b0;
         hit_q   <= 32'h0;
         miss_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         rd_q    <= rd_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
      end
   end

   // Tag and data arrays are qualified by valid, so they need no reset
   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

   // Gate the combinational outputs so reset drops them at once
   assign stall      = stall_c && !reset;
   assign cpu_rdata  = reset ? 32'h0 : rdata_c;
   assign mem_req    = (state_q == FILL) || (state_q == WRITE);
   assign mem_we     = (state_q == WRITE);
   assign mem_addr   = {cpu_addr[31:2], 2'b00};
   assign mem_wdata  = cpu_wdata;
   assign hit_count  = hit_q;
   assign miss_count = miss_q;

endmodule
